fsk_tx_serializer: RTL and testbench
====================================

FSK_TX_SERIALIZER -- requirements
Module: fsk_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5000, SHALL set clocks per transmitted bit (legal >= 2).
REQ-002 Parameter MARK_HALF, default 625, SHALL set half-period in clocks of the '1' tone (legal >= 1).
REQ-003 Parameter SPACE_HALF, default 500, SHALL set half-period in clocks of the '0' tone (legal >= 1).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 fifo_empty  input  1  byte FIFO empty flag.
REQ-007 fifo_r_data  input  8  FIFO head word, valid combinationally while fifo_empty=0 (show-ahead).
REQ-008 fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-009 tx_bit  output  1  current line bit (start/data/stop).
REQ-010 tone_out  output  1  square-wave transducer drive.
REQ-011 tx_en  output  1  transducer driver enable, high during any frame.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit exactly CLKS_PER_BIT clocks.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE with fifo_empty=1: SHALL remain IDLE, fifo_rd=0.
REQ-016 IDLE with fifo_empty=0: same cycle SHALL latch fifo_r_data into shift register, assert fifo_rd for exactly that cycle, next state START.
REQ-017 fifo_rd SHALL never be asserted while fifo_empty=1 and never for two consecutive cycles.
REQ-018 Bit counter SHALL count 0..CLKS_PER_BIT-1; at terminal count advance bit: START->DATA, DATA index 0..7 then ->STOP, STOP->next.
REQ-019 At STOP terminal count: fifo_empty=0 -> latch/pop per REQ-016 and go START (zero idle gap); else -> IDLE.
REQ-020 tx_bit SHALL be 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA.
REQ-021 Latency: first frame clock (START, tx_en=1) SHALL be the cycle after the fifo_rd pulse.
REQ-022 tone_out SHALL toggle every MARK_HALF clocks while tx_bit=1 in a frame, every SPACE_HALF clocks while tx_bit=0.
REQ-023 At every bit boundary the half-period counter SHALL restart at 0, tone_out level preserved (phase continuous).
REQ-024 tx_en=0 (IDLE) SHALL force tone_out=0 and hold the half-period counter at 0.
REQ-025 Counters SHALL be width $clog2 of their max value, wrap never reached beyond terminal count.
REQ-026 fifo_r_data changes while not in IDLE/STOP-terminal SHALL have no effect.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, all counters 0, shift register 0, fifo_rd=0, tx_bit=1, tone_out=0, tx_en=0, busy=0.
REQ-028 Reset mid-frame SHALL abandon the frame without a pop; the popped byte is lost.
REQ-029 After reset release, first possible fifo_rd SHALL be the first clock edge with reset=1 and fifo_empty=0.

Structure
REQ-030 Package fsk_tx_pkg SHALL hold the state enum, FRAME_DATA_BITS=8, START_BIT=0, STOP_BIT=1.
REQ-031 Tone generation SHALL be sub-module fsk_tone_gen (inputs enable, bit, restart; output tone); FSM and bit timing in top.

Verification (CLKS_PER_BIT=8, MARK_HALF=2, SPACE_HALF=1)
REQ-032 Reset, fifo_empty=1 for 50 clocks -> fifo_rd never 1, tx_bit=1, tone_out=0, busy=0.
REQ-033 One byte 0xA5 -> one fifo_rd pulse; tx_bit sequence 0,1,0,1,0,0,1,0,1,1 each 8 clocks; busy 80 clocks then 0.
REQ-034 Byte 0x0F: tone_out period 2 clocks during 0-bits, 4 clocks during 1-bits; counter restart at each boundary.
REQ-035 Three bytes 0x00,0xFF,0x55 queued -> three pops each exactly 80 clocks apart, no IDLE cycle between frames.
REQ-036 reset asserted at clock 30 of frame -> same-cycle outputs per REQ-027; with FIFO still non-empty, next frame starts with a new pop.
REQ-037 fifo_empty deasserted in the STOP terminal cycle -> pop in that cycle, START next cycle.

Source files
------------

// File: rtl/fsk_tx_pkg.sv
// -----------------------------------------------------------------------------
// fsk_tx_pkg
// Shared definitions for the FSK byte transmitter: the frame FSM state
// encoding and the fixed frame format (start bit, 8 data bits LSB first,
// stop bit).
// No ports (package).
// -----------------------------------------------------------------------------
package fsk_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/fsk_tx_serializer_tone.sv
// -----------------------------------------------------------------------------
// fsk_tone_gen
// Phase-continuous square-wave generator for the FSK transducer. While enabled
// the output toggles every MARK_HALF clocks when the line bit is 1 and every
// SPACE_HALF clocks when it is 0. A restart pulse (the last clock of a bit)
// zeroes the half-period counter without touching the output level, so the
// next bit starts a fresh half-period from the same level.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   i_enable   in   frame active; low forces tone to 0 and clears the counter
//   i_bit      in   current line bit, selects the half-period
//   i_restart  in   last clock of the current bit
//   o_tone     out  square-wave drive
// -----------------------------------------------------------------------------
module fsk_tone_gen #(
    parameter int MARK_HALF  = 625,
    parameter int SPACE_HALF = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_bit,
    input  logic i_restart,
    output logic o_tone
);

    localparam int MAX_HALF = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
    localparam int HALF_W   = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    localparam logic [HALF_W-1:0] MARK_TERM  = HALF_W'(MARK_HALF - 1);
    localparam logic [HALF_W-1:0] SPACE_TERM = HALF_W'(SPACE_HALF - 1);

    logic [HALF_W-1:0] r_half_cnt;
    logic              r_tone;
    logic [HALF_W-1:0] w_half_term;

    assign w_half_term = i_bit ? MARK_TERM : SPACE_TERM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_half_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (!i_enable) begin
            r_half_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (i_restart) begin
            // Bit boundary: restart timing, hold the level.
            r_half_cnt <= '0;
        end else if (r_half_cnt == w_half_term) begin
            r_half_cnt <= '0;
            r_tone     <= ~r_tone;
        end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
        end
    end

    // Gate with enable so the output drops in the same cycle the frame ends.
    assign o_tone = r_tone & i_enable;

endmodule

// File: rtl/fsk_tx_serializer.sv
// -----------------------------------------------------------------------------
// fsk_tx_serializer
// Pulls bytes from a show-ahead FIFO and sends each as a UART-style frame
// (start 0, 8 data bits LSB first, stop 1), CLKS_PER_BIT clocks per bit,
// while driving an FSK tone for the transducer. Frames run back to back
// with no idle gap when the FIFO still holds data at the end of a stop bit.
//
// FIFO handshake: fifo_empty=0 acts as "valid" and fifo_r_data is the head
// word; fifo_rd is the one-cycle "ready/pop". A byte transfers on a rising
// edge where fifo_rd=1, which only happens while fifo_empty=0, and the data is
// captured on that same edge.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   fifo_empty   in   FIFO empty flag
//   fifo_r_data  in   FIFO head byte (show-ahead)
//   fifo_rd      out  pop strobe
//   tx_bit       out  current line bit
//   tone_out     out  FSK square wave
//   tx_en        out  transducer enable, high during a frame
//   busy         out  high whenever not idle
//   dbg_state    out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module fsk_tx_serializer
    import fsk_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5000,
    parameter int MARK_HALF    = 625,
    parameter int SPACE_HALF   = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_rd,
    output logic       tx_bit,
    output logic       tone_out,
    output logic       tx_en,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W     = $clog2(FRAME_DATA_BITS);

    localparam logic [BIT_CNT_W-1:0] BIT_TERM = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_DATA_BITS - 1);

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [7:0]             r_shift;

    logic w_bit_term;
    logic w_load;
    logic w_restart;

    assign w_bit_term = (r_bit_cnt == BIT_TERM);

    // Next-state logic. w_load marks the cycle that pops the FIFO and
    // captures the head byte.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_load       = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_term) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_term && (r_bit_idx == IDX_LAST)) w_next_state = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_term) begin
                    if (!fifo_empty) begin
                        w_load       = 1'b1;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_shift   <= fifo_r_data;
                r_bit_cnt <= '0;
                r_bit_idx <= '0;
            end else if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_bit_term) begin
                r_bit_cnt <= '0;
                if ((r_state == ST_DATA) && (r_bit_idx != IDX_LAST)) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Reset is folded in so no pop is advertised while held in reset.
    assign fifo_rd = w_load & reset;

    always_comb begin
        tx_bit = STOP_BIT;
        case (r_state)
            ST_START: tx_bit = START_BIT;
            ST_DATA:  tx_bit = r_shift[0];
            default:  tx_bit = STOP_BIT;
        endcase
    end

    assign tx_en     = (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign w_restart = tx_en & w_bit_term;

    fsk_tone_gen #(
        .MARK_HALF  (MARK_HALF),
        .SPACE_HALF (SPACE_HALF)
    ) u_tone (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (tx_en),
        .i_bit     (tx_bit),
        .i_restart (w_restart),
        .o_tone    (tone_out)
    );

endmodule

// File: tb/tb_fsk_tx_serializer.sv
module tb_fsk_tx_serializer;

    localparam int CPB   = 8;
    localparam int MH    = 2;
    localparam int SH    = 1;
    localparam int FRAME = 10 * CPB;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd;
    logic       tx_bit;
    logic       tone_out;
    logic       tx_en;
    logic       busy;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fsk_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .MARK_HALF    (MH),
        .SPACE_HALF   (SH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .tx_bit      (tx_bit),
        .tone_out    (tone_out),
        .tx_en       (tx_en),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // FIFO contents as seen by the DUT, and the reference model's own copy.
    logic [7:0] fq[$];
    logic [7:0] mq[$];

    // Reference model: idle, or a position 0..FRAME-1 inside a frame.
    bit         m_busy;
    int         m_pos;
    logic [7:0] m_byte;
    logic       m_lvl;   // tone level at the start of the current bit

    task automatic drive_fifo();
        fifo_empty  = (fq.size() == 0);
        fifo_r_data = (fq.size() == 0) ? 8'($urandom) : fq[0];
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        mq.push_back(b);
        drive_fifo();
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_pos  = 0;
        m_byte = 8'h00;
        m_lvl  = 1'b0;
    endtask

    // One clock of the scenario: check outputs mid-cycle against the model,
    // then let the edge happen and advance FIFO and model.
    task automatic step_cycle(input string tag);
        logic e_tx, e_tone, e_busy, e_rd, dut_rd;
        int   bi, k, h;
        bi = m_pos / CPB;
        k  = m_pos % CPB;
        if (!m_busy) begin
            e_tx = 1'b1; e_tone = 1'b0; e_busy = 1'b0;
            e_rd = (mq.size() > 0);
        end else begin
            if (bi == 0)      e_tx = 1'b0;
            else if (bi == 9) e_tx = 1'b1;
            else              e_tx = m_byte[bi-1];
            h      = e_tx ? MH : SH;
            e_tone = m_lvl ^ (((k / h) % 2) == 1);
            e_busy = 1'b1;
            e_rd   = (m_pos == FRAME - 1) && (mq.size() > 0);
        end
        @(negedge clk);
        n_checks += 5;
        if (tx_bit !== e_tx) begin
            n_fail++;
            $display("FAIL %s tx_bit cyc=%0d pos=%0d got=%b exp=%b", tag, cyc, m_pos, tx_bit, e_tx);
        end
        if (tone_out !== e_tone) begin
            n_fail++;
            $display("FAIL %s tone_out cyc=%0d pos=%0d got=%b exp=%b", tag, cyc, m_pos, tone_out, e_tone);
        end
        if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s busy cyc=%0d pos=%0d got=%b exp=%b", tag, cyc, m_pos, busy, e_busy);
        end
        if (tx_en !== e_busy) begin
            n_fail++;
            $display("FAIL %s tx_en cyc=%0d pos=%0d got=%b exp=%b", tag, cyc, m_pos, tx_en, e_busy);
        end
        if (fifo_rd !== e_rd) begin
            n_fail++;
            $display("FAIL %s fifo_rd cyc=%0d pos=%0d got=%b exp=%b", tag, cyc, m_pos, fifo_rd, e_rd);
        end
        dut_rd = fifo_rd;
        @(posedge clk);
        #1;
        cyc++;
        if (dut_rd === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        if (!m_busy) begin
            if (e_rd) begin
                m_byte = mq.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
                m_lvl  = 1'b0;
            end
        end else begin
            if (k == CPB - 1) m_lvl = e_tone;
            if (m_pos == FRAME - 1) begin
                if (e_rd) begin
                    m_byte = mq.pop_front();
                    m_pos  = 0;
                end else begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
            end
        end
        drive_fifo();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks += 5;
        if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL %s fifo_rd got=%b exp=0", tag, fifo_rd); end
        if (tx_bit !== 1'b1)  begin n_fail++; $display("FAIL %s tx_bit got=%b exp=1", tag, tx_bit); end
        if (tone_out !== 1'b0) begin n_fail++; $display("FAIL %s tone_out got=%b exp=0", tag, tone_out); end
        if (tx_en !== 1'b0)   begin n_fail++; $display("FAIL %s tx_en got=%b exp=0", tag, tx_en); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL %s busy got=%b exp=0", tag, busy); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        drive_fifo();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (50) step_cycle("idle_empty");
    endtask

    task automatic test_single();
        push(8'hA5);
        repeat (FRAME + 6) step_cycle("single_a5");
    endtask

    task automatic test_tone();
        push(8'h0F);
        repeat (FRAME + 6) step_cycle("tone_0f");
    endtask

    task automatic test_back_to_back();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        repeat (3 * FRAME + 6) step_cycle("b2b");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push(8'($urandom));
            repeat (n * FRAME + $urandom_range(2, 6)) step_cycle("random");
        end
    endtask

    task automatic test_stop_edge();
        int guard;
        push(8'h96);
        guard = 0;
        while (!(m_busy && m_pos == FRAME - 1) && guard < 200) begin
            step_cycle("stop_edge");
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL stop_edge_timeout got=%0d exp<200", guard);
        end
        // FIFO becomes non-empty exactly in the stop terminal cycle.
        push(8'h69);
        repeat (FRAME + 6) step_cycle("stop_edge");
    endtask

    task automatic test_mid_reset();
        int guard;
        push(8'h3C);
        push(8'hC3);
        guard = 0;
        while (!(m_busy && m_pos == 30) && guard < 200) begin
            step_cycle("mid_reset_pre");
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL mid_reset_timeout got=%0d exp<200", guard);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset_async");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_held");
        reset = 1'b1;
        model_reset();
        repeat (FRAME + 6) step_cycle("mid_reset_post");
    endtask

    initial begin
        reset       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_r_data = 8'h00;
        test_reset();
        test_single();
        test_tone();
        test_back_to_back();
        test_stop_edge();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
